// File: rtl/mux_arb.sv
// mux_arb: N-channel registered multiplexer with arbitration.
//
// Several producers offer WIDTH-bit words; one is granted per cycle and
// captured in a single output register that feeds one consumer.
//
// Optional feature macro: MUX_ARB_RR_EN
//   defined   -> round-robin arbitration around a `last` pointer
//   undefined -> fixed priority, lowest channel index wins
//
// Handshake semantics (all ports): a word moves on a rising edge exactly
// when valid and ready are both high in the cycle before that edge. A
// producer may drop in_valid at any time before it is granted. in_ready
// is a combinational grant: it is one-hot when a word is taken this cycle
// and zero otherwise. It depends on in_valid, ovr, ovr_sel, out_valid,
// out_ready and rst, and never on in_data. out_valid stays high and
// out_data/out_chan stay frozen until the consumer raises out_ready.
module mux_arb #(
  parameter int WIDTH = 3,
  parameter int N     = 4,
  localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N*WIDTH-1:0] i_in_data,
  input  logic [N-1:0]       i_in_valid,
  output logic [N-1:0]       o_in_ready,
  input  logic               i_ovr,
  input  logic [CW-1:0]      i_ovr_sel,
  output logic [WIDTH-1:0]   o_out_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [CW-1:0]      o_out_chan
);

  // Output register.
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [CW-1:0]    r_out_chan;

  // Arbitration results.
  logic [N-1:0]     w_elig;
  logic             w_load_en;
  logic             w_found;
  logic [CW-1:0]    w_win;
  logic [WIDTH-1:0] w_win_data;

`ifdef MUX_ARB_RR_EN
  // Index of the most recent non-override grant. Search starts one above it.
  logic [CW-1:0]    r_last;
`endif

  // The output register may take a new word when it is empty or being drained.
  assign w_load_en = !r_out_valid || i_out_ready;

  // Eligible set: every requester, or only the forced channel under override.
  // An out-of-range forced index leaves the set empty.
  always_comb begin
    w_elig = '0;
    if (i_ovr) begin
      if (int'(i_ovr_sel) < N) begin
        w_elig[i_ovr_sel] = i_in_valid[i_ovr_sel];
      end
    end else begin
      w_elig = i_in_valid;
    end
  end

`ifdef MUX_ARB_RR_EN
  // Round-robin winner: first eligible channel at last+1, last+2, ... mod N.
  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      v_idx = (int'(r_last) + k) % N;
      if (!w_found && w_elig[v_idx]) begin
        w_found = 1'b1;
        w_win   = CW'(v_idx);
      end
    end
  end
`else
  // Fixed-priority winner: the lowest eligible index. The loop runs from the
  // top so that the last assignment made is the lowest index.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_found = 1'b1;
        w_win   = CW'(k);
      end
    end
  end
`endif

  // Data of the winning channel. Only the winner index steers this mux, so
  // in_data has no path into in_ready.
  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win == CW'(i)) begin
        w_win_data = i_in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grant strobe. It is suppressed while in reset so that no producer sees a
  // handshake that the cleared output register would never keep.
  always_comb begin
    o_in_ready = '0;
    if (!i_rst && w_load_en && w_found) begin
      o_in_ready[w_win] = 1'b1;
    end
  end

  // Output register: load the winner, go empty when nothing is eligible,
  // hold everything while stalled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
    end else if (w_load_en) begin
      if (w_found) begin
        r_out_data  <= w_win_data;
        r_out_chan  <= w_win;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_ARB_RR_EN
  // Pointer tracks non-override grants only; forced grants leave it alone so
  // the normal rotation resumes where it stopped. Reset to N-1 makes channel 0
  // the first choice.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= CW'(N - 1);
    end else if (w_load_en && w_found && !i_ovr) begin
      r_last <= w_win;
    end
  end
`endif

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_out_chan  = r_out_chan;

endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: directed bench for mux_arb (WIDTH=3, N=4). Expected output words
// are queued when the stimulus that causes them is issued; a monitor pops and
// compares each word the consumer accepts.
module tb_mux_arb;

  localparam int WIDTH = 3;
  localparam int N     = 4;
  localparam int CW    = 2;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic [N*WIDTH-1:0] i_in_data;
  logic [N-1:0]       i_in_valid;
  logic [N-1:0]       o_in_ready;
  logic               i_ovr;
  logic [CW-1:0]      i_ovr_sel;
  logic [WIDTH-1:0]   o_out_data;
  logic               o_out_valid;
  logic               i_out_ready;
  logic [CW-1:0]      o_out_chan;

  always #5 clk = ~clk;

  mux_arb #(.WIDTH(WIDTH), .N(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_data   (i_in_data),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_ovr       (i_ovr),
    .i_ovr_sel   (i_ovr_sel),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_chan  (o_out_chan)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [CW+WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive at the falling edge, check the combinational grant 1ns
  // later, and queue the word that the next rising edge should capture.
  task automatic step(input logic [N-1:0] v, input logic [N*WIDTH-1:0] d,
                      input logic ovr, input logic [CW-1:0] sel, input logic ordy,
                      input logic [N-1:0] exp_rdy, input logic push,
                      input logic [CW-1:0] exp_ch);
    logic [WIDTH-1:0] w;
    @(negedge clk);
    i_in_valid  = v;
    i_in_data   = d;
    i_ovr       = ovr;
    i_ovr_sel   = sel;
    i_out_ready = ordy;
    #1;
    check("in_ready", 32'(o_in_ready), 32'(exp_rdy));
    if (push) begin
      w = d[exp_ch*WIDTH +: WIDTH];
      exp_q.push_back({exp_ch, w});
    end
  endtask

  task automatic idle();
    step('0, '0, 1'b0, '0, 1'b1, '0, 1'b0, '0);
  endtask

  // ---------------- monitor ----------------
  // A word leaves on the rising edge when out_valid && out_ready; sample
  // 2ns before that edge.
  initial begin
    logic [CW+WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (o_out_valid && i_out_ready && !rst) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL out_word: got chan %0d data %0h, expected no word", o_out_chan, o_out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_word", 32'({o_out_chan, o_out_data}), 32'(e));
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Channel data packed {ch3, ch2, ch1, ch0}.
  localparam logic [11:0] D1 = {3'd6, 3'b101, 3'd3, 3'd1};
  localparam logic [11:0] D0 = {3'd1, 3'd2, 3'd3, 3'b110};
  localparam logic [11:0] D2 = {3'd4, 3'd3, 3'd2, 3'd7};
  localparam logic [11:0] D3 = {3'd5, 3'd1, 3'd4, 3'd2};
  localparam logic [11:0] D4 = {3'd3, 3'd6, 3'd5, 3'd4};

`ifdef MUX_ARB_RR_EN
  int seq_all[5] = '{0, 1, 2, 3, 0};
  localparam logic [1:0] BP_CH  = 2'd3;
  localparam logic [1:0] OVR_CH = 2'd1;
`else
  int seq_all[5] = '{0, 0, 0, 0, 0};
  localparam logic [1:0] BP_CH  = 2'd1;
  localparam logic [1:0] OVR_CH = 2'd0;
`endif

  initial begin
    // Reset held from time 0 with every channel requesting.
    rst = 1'b1;
    i_in_valid = '1; i_in_data = D1; i_ovr = 1'b0; i_ovr_sel = '0; i_out_ready = 1'b1;
    #2;
    check("rst_in_ready", 32'(o_in_ready), 0);
    check("rst_out_valid", 32'(o_out_valid), 0);
    check("rst_out_data", 32'(o_out_data), 0);
    check("rst_out_chan", 32'(o_out_chan), 0);
    @(negedge clk);
    rst = 1'b0;
    i_in_valid = '0;
    idle();
    check("idle_out_valid", 32'(o_out_valid), 0);

    // Single channel: ch2 with 3'b101.
    step(4'b0100, D1, 1'b0, '0, 1'b1, 4'b0100, 1'b1, 2'd2);
    idle();
    idle();

    // Mid-cycle reset drops a stalled word.
    step(4'b0001, D0, 1'b0, '0, 1'b0, 4'b0001, 1'b0, '0);
    step(4'b0000, D0, 1'b0, '0, 1'b0, 4'b0000, 1'b0, '0);
    check("stall_valid", 32'(o_out_valid), 1);
    check("stall_data", 32'(o_out_data), 32'(3'b110));
    #1;
    i_in_valid = '1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(o_out_valid), 0);
    check("mid_rst_out_data", 32'(o_out_data), 0);
    check("mid_rst_out_chan", 32'(o_out_chan), 0);
    check("mid_rst_in_ready", 32'(o_in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    i_in_valid = '0;

    // All channels requesting, consumer always ready.
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, D2, 1'b0, '0, 1'b1, 4'(1 << seq_all[k]), 1'b1, 2'(seq_all[k]));
    end
    idle();

    // Backpressure: hold a ch1 word for three cycles with ch1 and ch3 waiting.
    step(4'b0010, D3, 1'b0, '0, 1'b1, 4'b0010, 1'b1, 2'd1);
    for (int k = 0; k < 3; k++) begin
      step(4'b1010, D3, 1'b0, '0, 1'b0, 4'b0000, 1'b0, '0);
      check("bp_chan", 32'(o_out_chan), 1);
      check("bp_data", 32'(o_out_data), 4);
      check("bp_valid", 32'(o_out_valid), 1);
    end
    step(4'b1010, D3, 1'b0, '0, 1'b1, 4'(1 << BP_CH), 1'b1, BP_CH);
    idle();

    // Override: pointer set by a ch0 grant, then a forced ch3 grant must not move it.
    step(4'b0001, D4, 1'b0, '0, 1'b1, 4'b0001, 1'b1, 2'd0);
    step(4'b1001, D4, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1, 2'd3);
    step(4'b1111, D4, 1'b0, '0, 1'b1, 4'(1 << OVR_CH), 1'b1, OVR_CH);
    step(4'b0001, D4, 1'b1, 2'd3, 1'b1, 4'b0000, 1'b0, '0);
    idle();
    check("ovr_empty_valid", 32'(o_out_valid), 0);

    // Drain and refill in the same cycle keeps out_valid high.
    step(4'b0001, D4, 1'b0, '0, 1'b1, 4'b0001, 1'b1, 2'd0);
    step(4'b0010, D4, 1'b0, '0, 1'b1, 4'b0010, 1'b1, 2'd1);
    check("refill_valid_before", 32'(o_out_valid), 1);
    idle();
    check("refill_valid_after", 32'(o_out_valid), 1);
    check("refill_chan", 32'(o_out_chan), 1);
    idle();
    idle();
    check("final_out_valid", 32'(o_out_valid), 0);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
